// File: rtl/cherry_uart_pkg.sv
// rtl/cherry_uart_pkg.sv - shared UART receive types, constants and baud helper
package cherry_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer for an asynchronous UART input, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - UART 8N1 deframer to byte + strobe; define UART_RX_PARITY_EN for 8E1 framing
module uart_byte_rx
  import cherry_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_interrupt,
  output logic [7:0] rx_data,
  output logic       frame_error,
  output logic       parity_error
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t                 state_q, state_d;
  logic [TW-1:0]             tick_q, tick_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      irq_q, irq_d;
  logic                      ferr_q, ferr_d;
  logic                      tick_last;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      perr_q, perr_d;
`endif

  assign tick_last = (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      // Mid start bit: a line that already went high was only a glitch.
      START: if (tick_q == TICK_HALF) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (tick_last && bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick_last) state_d = STOP;
`endif
      // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
      STOP:  if (tick_last) state_d = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d  = tick_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    irq_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        tick_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_last) begin
          tick_d    = '0;
          par_bad_d = rx_s ^ (^shift_q);
        end
      end
`endif
      STOP: begin
        if (tick_last) begin
          tick_d = '0;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d = shift_q;
            irq_d  = 1'b1;
          end
        end
      end
      default: tick_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      irq_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign rx_interrupt = irq_q;
  assign rx_data      = data_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx with a frame-level reference model
module tb_uart_byte_rx;
  import cherry_uart_pkg::*;

  localparam int CPB    = 10;
  localparam int K_BYTE = 0;
  localparam int K_FRM  = 1;
  localparam int K_PAR  = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_interrupt;
  logic [7:0] rx_data;
  logic       frame_error;
  logic       parity_error;

  uart_byte_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_interrupt (rx_interrupt),
    .rx_data      (rx_data),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_strobe_cyc = 0;
  logic [7:0] model_last = 8'h00;
  bit         prev_strobe = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    int   k;
    exp_t e;
    bit   any;
    if (!reset) begin
      prev_strobe = 1'b0;
    end else begin
      any = rx_interrupt | frame_error | parity_error;
      if (any) begin
        k = rx_interrupt ? K_BYTE : (frame_error ? K_FRM : K_PAR);
        check("one_strobe", 32'(rx_interrupt) + 32'(frame_error) + 32'(parity_error), 1);
        check("no_back_to_back", 32'(prev_strobe), 0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got kind %0d data %0h expected none", k, rx_data);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", k, e.kind);
          check("rx_data", rx_data, e.data);
        end
        last_strobe_cyc = cyc;
      end
      prev_strobe = any;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    clks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    exp_t e;
    if (!stop_v) begin
      e.kind = K_FRM;
    end else if (PAR_ON && par_flip) begin
      e.kind = K_PAR;
    end else begin
      e.kind = K_BYTE;
      model_last = d;
    end
    e.data = model_last;
    sb.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_ON) drive_bit((^d) ^ par_flip);
    drive_bit(stop_v);
  endtask

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) clks(1);
    check(nm, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_lat;
    logic [7:0] d;
    logic       sv;
    logic       pf;

    clks(3);
    check("reset_irq", rx_interrupt, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_ferr", frame_error, 0);
    check("reset_perr", parity_error, 0);
    reset = 1'b1;
    clks(5);

    // single frame and latency from start edge
    send_frame(8'hA5, 1'b1, 1'b0);
    drain("t1_drain", 300);
    lat = last_strobe_cyc - start_cyc;
    exp_lat = 2 + CPB / 2 + 9 * CPB + (PAR_ON ? CPB : 0) + 1;
    check("t1_latency_ok", 32'((lat >= exp_lat - 1) && (lat <= exp_lat + 1)), 1);
    clks(20);

    // back-to-back with one stop bit
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0);
    drain("t2_drain", 300);

    // framing error then long break, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    clks(50 * CPB);
    drain("t3_ferr_drain", 10);
    rx = 1'b1;
    clks(2 * CPB);
    send_frame(8'h55, 1'b1, 1'b0);
    drain("t3_drain", 300);
    clks(CPB);

    // short glitch on idle line
    rx = 1'b0;
    clks(3);
    rx = 1'b1;
    clks(2 * CPB);
    check("t4_idle_state", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'hFF, 1'b1, 1'b0);
    drain("t4_drain", 300);
    clks(CPB);

    // reset asserted during bit 4 of 8'h81, held past the frame
    d = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    clks(CPB / 2);
    reset = 1'b0;
    clks(CPB - CPB / 2);
    for (int i = 5; i < 8; i++) drive_bit(d[i]);
    if (PAR_ON) drive_bit(^d);
    drive_bit(1'b1);
    clks(2 * CPB);
    check("t5_reset_data", rx_data, 8'h00);
    check("t5_reset_irq", rx_interrupt, 0);
    reset = 1'b1;
    model_last = 8'h00;
    clks(CPB);
    send_frame(8'h7E, 1'b1, 1'b0);
    drain("t5_drain", 300);
    clks(CPB);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    send_frame(8'h03, 1'b1, 1'b0);
    drain("t6_drain", 300);
    clks(CPB);
`endif

    // randomized frames: occasional framing/parity faults, random idle gaps
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      sv = ($urandom_range(0, 5) != 0);
      pf = ($urandom_range(0, 3) == 0);
      send_frame(d, sv, pf);
      rx = 1'b1;
      if (!sv) clks(CPB + $urandom_range(0, 15));
      else clks($urandom_range(0, 15));
    end
    drain("rand_drain", 400);
    clks(5 * CPB);
    check("final_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
